// File: rtl/present_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : present_run_sequencer
// Purpose  : Runs one PRESENT UUT operation per request: reset pulse, key
//            schedule wait, enc/dec wait, result and latency capture.
// Revision : 1.0
// ============================================================================
module present_run_sequencer #(
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [63:0]      block_i,
    input  logic [79:0]      key_i,
    input  logic             encdec_i,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [63:0]      result,
    output logic [CNT_W-1:0] key_cycles,
    output logic [CNT_W-1:0] op_cycles,
    output logic             rst_uut,
    output logic [63:0]      block_i_uut,
    output logic [79:0]      key_uut,
    output logic             encdec_uut,
    input  logic [63:0]      block_o_uut,
    input  logic             end_key_signal_uut,
    input  logic             end_enc_uut,
    input  logic             end_dec_uut
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_UUT_RST  = 3'd1,
        S_WAIT_KEY = 3'd2,
        S_WAIT_OP  = 3'd3,
        S_FINISH   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_rst_last   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_timeout_m1 = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout_err;
    logic [63:0]      r_result;
    logic [CNT_W-1:0] r_key_cycles;
    logic [CNT_W-1:0] r_op_cycles;
    logic             r_rst_uut;
    logic [63:0]      r_block_i_uut;
    logic [79:0]      r_key_uut;
    logic             r_encdec_uut;

    logic             w_op_end;
    logic [CNT_W-1:0] w_cnt_inc;

    // Only the end flag matching the latched direction completes the run.
    assign w_op_end  = r_encdec_uut ? end_enc_uut : end_dec_uut;
    assign w_cnt_inc = (r_cnt == c_timeout) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_result      <= '0;
            r_key_cycles  <= '0;
            r_op_cycles   <= '0;
            r_rst_uut     <= 1'b1;
            r_block_i_uut <= '0;
            r_key_uut     <= '0;
            r_encdec_uut  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort && (r_state != S_IDLE)) begin
                r_state   <= S_IDLE;
                r_rst_uut <= 1'b1;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_rst_uut <= 1'b1;
                        if (start) begin
                            r_block_i_uut <= block_i;
                            r_key_uut     <= key_i;
                            r_encdec_uut  <= encdec_i;
                            r_timeout_err <= 1'b0;
                            r_key_cycles  <= '0;
                            r_op_cycles   <= '0;
                            r_result      <= '0;
                            r_cnt         <= '0;
                            r_busy        <= 1'b1;
                            r_state       <= S_UUT_RST;
                        end
                    end
                    S_UUT_RST: begin
                        if (r_cnt == c_rst_last) begin
                            r_cnt     <= '0;
                            r_rst_uut <= 1'b0;
                            r_state   <= S_WAIT_KEY;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_WAIT_KEY: begin
                        if (end_key_signal_uut) begin
                            r_key_cycles <= r_cnt + 1'b1;
                            r_cnt        <= '0;
                            r_state      <= S_WAIT_OP;
                        end else if (r_cnt == c_timeout_m1) begin
                            r_key_cycles  <= c_timeout;
                            r_timeout_err <= 1'b1;
                            r_done        <= 1'b1;
                            r_rst_uut     <= 1'b1;
                            r_state       <= S_FINISH;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_WAIT_OP: begin
                        if (w_op_end) begin
                            r_op_cycles <= r_cnt + 1'b1;
                            r_result    <= block_o_uut;
                            r_done      <= 1'b1;
                            r_rst_uut   <= 1'b1;
                            r_state     <= S_FINISH;
                        end else if (r_cnt == c_timeout_m1) begin
                            r_op_cycles   <= c_timeout;
                            r_timeout_err <= 1'b1;
                            r_done        <= 1'b1;
                            r_rst_uut     <= 1'b1;
                            r_state       <= S_FINISH;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_FINISH: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_rst_uut <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout_err = r_timeout_err;
    assign result      = r_result;
    assign key_cycles  = r_key_cycles;
    assign op_cycles   = r_op_cycles;
    assign rst_uut     = r_rst_uut;
    assign block_i_uut = r_block_i_uut;
    assign key_uut     = r_key_uut;
    assign encdec_uut  = r_encdec_uut;

endmodule
`default_nettype wire

// File: tb/tb_present_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_present_run_sequencer
// Purpose  : Directed bench for present_run_sequencer with a latency-model UUT.
// Revision : 1.0
// ============================================================================
module tb_present_run_sequencer;

    localparam int c_cnt_w = 32;

    logic               clk;
    logic               rst;
    logic               start;
    logic               abort;
    logic [63:0]        block_i;
    logic [79:0]        key_i;
    logic               encdec_i;
    logic               busy;
    logic               done;
    logic               timeout_err;
    logic [63:0]        result;
    logic [c_cnt_w-1:0] key_cycles;
    logic [c_cnt_w-1:0] op_cycles;
    logic               rst_uut;
    logic [63:0]        block_i_uut;
    logic [79:0]        key_uut;
    logic               encdec_uut;
    logic [63:0]        block_o_uut;
    logic               end_key_signal_uut;
    logic               end_enc_uut;
    logic               end_dec_uut;

    int n_cmp  = 0;
    int n_fail = 0;

    // UUT latency model: cycles since rst_uut fell, with per-run latencies.
    int          uc;
    int          key_lat  = 32;
    int          op_lat   = 31;
    bit          key_never = 1'b0;
    bit          enc_hold  = 1'b0;
    logic [63:0] model_out = 64'h0;
    logic        op_ready;

    present_run_sequencer #(
        .RST_CYCLES (4),
        .CNT_W      (c_cnt_w),
        .TIMEOUT    (100)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .abort              (abort),
        .block_i            (block_i),
        .key_i              (key_i),
        .encdec_i           (encdec_i),
        .busy               (busy),
        .done               (done),
        .timeout_err        (timeout_err),
        .result             (result),
        .key_cycles         (key_cycles),
        .op_cycles          (op_cycles),
        .rst_uut            (rst_uut),
        .block_i_uut        (block_i_uut),
        .key_uut            (key_uut),
        .encdec_uut         (encdec_uut),
        .block_o_uut        (block_o_uut),
        .end_key_signal_uut (end_key_signal_uut),
        .end_enc_uut        (end_enc_uut),
        .end_dec_uut        (end_dec_uut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) uc <= rst_uut ? 0 : uc + 1;

    assign end_key_signal_uut = !rst_uut && !key_never && (uc >= key_lat - 1);
    assign op_ready           = end_key_signal_uut && (uc >= key_lat - 1 + op_lat);
    assign end_enc_uut        = enc_hold || (encdec_uut && op_ready);
    assign end_dec_uut        = !encdec_uut && op_ready;
    assign block_o_uut        = op_ready ? model_out : 64'hDEAD_BEEF_DEAD_BEEF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [63:0] blk, input logic [79:0] key, input logic dir);
        block_i  = blk;
        key_i    = key;
        encdec_i = dir;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_rst_low(output int n);
        n = 0;
        while (rst_uut !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
    endtask

    int n;
    bit saw_done;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        block_i  = '0;
        key_i    = '0;
        encdec_i = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rst_uut", rst_uut, 1);
        chk("rst_result", result, 0);
        chk("rst_key_cycles", key_cycles, 0);
        chk("rst_block_i_uut", block_i_uut, 0);
        rst = 1'b0;
        tick();

        // Run 1: encrypt all-zero block with zero key.
        key_lat = 32; op_lat = 31; model_out = 64'h5579C1387B228445;
        launch(64'h0, 80'h0, 1'b1);
        chk("r1_busy", busy, 1);
        wait_rst_low(n);
        chk("r1_rst_cycles", n, 4);
        wait_done(n);
        chk("r1_done", done, 1);
        chk("r1_latency", n, 63);
        chk("r1_result", result, 64'h5579C1387B228445);
        chk("r1_key_cycles", key_cycles, 32);
        chk("r1_op_cycles", op_cycles, 31);
        chk("r1_timeout_err", timeout_err, 0);
        chk("r1_rst_uut_finish", rst_uut, 1);
        tick();
        chk("r1_done_pulse", done, 0);
        chk("r1_busy_idle", busy, 0);

        // Run 2: decrypt with end_enc stuck high; only end_dec may complete.
        enc_hold = 1'b1; model_out = 64'h0;
        launch(64'h5579C1387B228445, 80'h0, 1'b0);
        chk("r2_block_i_uut", block_i_uut, 64'h5579C1387B228445);
        chk("r2_encdec_uut", encdec_uut, 0);
        wait_rst_low(n);
        wait_done(n);
        chk("r2_done", done, 1);
        chk("r2_result", result, 64'h0);
        chk("r2_op_cycles", op_cycles, 31);
        enc_hold = 1'b0;
        tick();

        // Run 3: key schedule never completes.
        key_never = 1'b1;
        launch(64'h1111_2222_3333_4444, 80'h5, 1'b1);
        wait_rst_low(n);
        wait_done(n);
        chk("r3_done", done, 1);
        chk("r3_timeout_latency", n, 100);
        chk("r3_timeout_err", timeout_err, 1);
        chk("r3_key_cycles", key_cycles, 100);
        chk("r3_op_cycles", op_cycles, 0);
        chk("r3_result", result, 0);
        key_never = 1'b0;
        tick();
        chk("r3_err_sticky", timeout_err, 1);

        // Run 4: end_key and end_enc rise together.
        key_lat = 10; op_lat = 0; model_out = 64'h0123456789ABCDEF;
        launch(64'hAAAA_BBBB_CCCC_DDDD, 80'h1234, 1'b1);
        chk("r4_err_cleared", timeout_err, 0);
        chk("r4_key_cycles_cleared", key_cycles, 0);
        wait_rst_low(n);
        wait_done(n);
        chk("r4_done", done, 1);
        chk("r4_latency", n, 11);
        chk("r4_key_cycles", key_cycles, 10);
        chk("r4_op_cycles", op_cycles, 1);
        chk("r4_result", result, 64'h0123456789ABCDEF);
        tick();

        // Run 5: ignored mid-run start, then abort coinciding with end_enc.
        key_lat = 5; op_lat = 3; model_out = 64'hFEED_FACE_CAFE_F00D;
        launch(64'h0F0F_0F0F_0F0F_0F0F, 80'hABCDE, 1'b1);
        wait_rst_low(n);
        block_i  = 64'h7777_7777_7777_7777;
        key_i    = 80'h99;
        encdec_i = 1'b0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk("r5_block_kept", block_i_uut, 64'h0F0F_0F0F_0F0F_0F0F);
        chk("r5_key_kept", key_uut, 80'hABCDE);
        chk("r5_dir_kept", encdec_uut, 1);
        n = 0;
        while (end_enc_uut !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("r5_end_enc_seen", end_enc_uut, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("r5_abort_busy", busy, 0);
        chk("r5_abort_done", done, 0);
        chk("r5_abort_rst_uut", rst_uut, 1);
        chk("r5_abort_op_cycles", op_cycles, 0);
        chk("r5_abort_result", result, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk("r5_no_late_done", saw_done, 0);

        // Run 6: asynchronous reset in WAIT_KEY, then a clean run.
        key_lat = 20; op_lat = 5;
        launch(64'h1357_9BDF_2468_ACE0, 80'hFFFF, 1'b1);
        wait_rst_low(n);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("r6_async_busy", busy, 0);
        chk("r6_async_rst_uut", rst_uut, 1);
        chk("r6_async_block", block_i_uut, 0);
        chk("r6_async_key", key_uut, 0);
        chk("r6_async_dir", encdec_uut, 0);
        tick();
        rst = 1'b0;
        tick();
        key_lat = 7; op_lat = 4; model_out = 64'h0BAD_C0DE_0BAD_C0DE;
        launch(64'h2222_0000_2222_0000, 80'h42, 1'b0);
        wait_rst_low(n);
        chk("r6_rst_cycles", n, 4);
        wait_done(n);
        chk("r6_done", done, 1);
        chk("r6_result", result, 64'h0BAD_C0DE_0BAD_C0DE);
        chk("r6_key_cycles", key_cycles, 7);
        chk("r6_op_cycles", op_cycles, 4);
        chk("r6_timeout_err", timeout_err, 0);
        tick();
        chk("r6_busy_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
